// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard for the decode stage.
// Each architectural register 1..31 carries a 2-bit count of writes issued
// but not yet retired. The decode stage is held while it would read a busy
// register, or while its own destination count is already saturated.
// Register 0 is hardwired to zero and is never tracked.
module reg_scoreboard (
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  src1_addr,
    input  logic        src1_used,
    input  logic [4:0]  src2_addr,
    input  logic        src2_used,
    input  logic        id_valid,
    input  logic        issue_fire,
    input  logic        issue_we,
    input  logic [4:0]  issue_dest,
    input  logic        retire_we,
    input  logic [4:0]  retire_dest,
    output logic        id_stall,
    output logic [31:0] busy_vec,
    output logic [15:0] stall_cnt,
    output logic        err_underflow
);

    // Registered state. Entry 0 of cnt_r / busy_r is held at zero.
    logic [31:0][1:0] cnt_r;
    logic [31:0]      busy_r;
    logic [15:0]      stall_cnt_r;
    logic             err_r;

    // Combinational next-state and decode terms.
    logic [31:0][1:0] cnt_nxt_s;
    logic [31:0]      busy_nxt_s;
    logic             inc_s;
    logic             dec_s;
    logic             same_s;
    logic             underflow_s;
    logic             src1_hit_s;
    logic             src2_hit_s;
    logic             sat_s;
    logic             stall_s;

    // One counter step: saturate at 3 on increment, floor at 0 on
    // decrement, and cancel when both hit the same register.
    function automatic logic [1:0] cnt_step(
        input logic [1:0] cnt,
        input logic       inc,
        input logic       dec
    );
        logic [1:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = (cnt == 2'd3) ? cnt : cnt + 2'd1;
            2'b01:   res = (cnt == 2'd0) ? cnt : cnt - 2'd1;
            2'b11:   res = cnt;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Decode issue/retire events; writes to r0 are discarded.
    always_comb begin
        inc_s       = issue_fire & issue_we & (issue_dest != 5'd0);
        dec_s       = retire_we & (retire_dest != 5'd0);
        same_s      = inc_s & dec_s & (issue_dest == retire_dest);
        underflow_s = dec_s & (cnt_r[retire_dest] == 2'd0) & ~same_s;
    end

    // Next counter values and the busy bits they imply.
    always_comb begin
        cnt_nxt_s  = '0;
        busy_nxt_s = 32'h0;
        for (int n = 1; n < 32; n++) begin
            cnt_nxt_s[n]  = cnt_step(cnt_r[n],
                                     inc_s & (issue_dest == 5'(n)),
                                     dec_s & (retire_dest == 5'(n)));
            busy_nxt_s[n] = (cnt_nxt_s[n] != 2'd0);
        end
    end

    // Decode hold: hazards come from registered state only, so a retire in
    // this cycle is not yet visible and issue_fire is never consulted.
    always_comb begin
        src1_hit_s = src1_used & busy_r[src1_addr];
        src2_hit_s = src2_used & busy_r[src2_addr];
        sat_s      = issue_we & (issue_dest != 5'd0) &
                     (cnt_r[issue_dest] == 2'd3);
        stall_s    = id_valid & (src1_hit_s | src2_hit_s | sat_s);
    end

    // State update with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r       <= '0;
            busy_r      <= 32'h0;
            stall_cnt_r <= 16'h0;
            err_r       <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            busy_r <= busy_nxt_s;
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (underflow_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign id_stall      = stall_s;
    assign busy_vec      = busy_r;
    assign stall_cnt     = stall_cnt_r;
    assign err_underflow = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios plus randomized traffic checked by a
// queue-based scoreboard against a pending-write count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  src1_addr;
    logic        src1_used;
    logic [4:0]  src2_addr;
    logic        src2_used;
    logic        id_valid;
    logic        issue_fire;
    logic        issue_we;
    logic [4:0]  issue_dest;
    logic        retire_we;
    logic [4:0]  retire_dest;
    logic        id_stall;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;
    logic        err_underflow;

    reg_scoreboard dut (
        .clk          (clk),
        .resetn       (resetn),
        .src1_addr    (src1_addr),
        .src1_used    (src1_used),
        .src2_addr    (src2_addr),
        .src2_used    (src2_used),
        .id_valid     (id_valid),
        .issue_fire   (issue_fire),
        .issue_we     (issue_we),
        .issue_dest   (issue_dest),
        .retire_we    (retire_we),
        .retire_dest  (retire_dest),
        .id_stall     (id_stall),
        .busy_vec     (busy_vec),
        .stall_cnt    (stall_cnt),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] busy;
        logic [15:0] scnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: outstanding write count per register.
    int   pend[32];
    int   m_scnt;
    bit   m_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_scnt = 0;
        m_err  = 1'b0;
    endtask

    // One clock cycle of stimulus. When respect is set, fire is suppressed
    // while the model says the decode stage must hold.
    task automatic cycle(input bit rn, input bit v,
                         input logic [4:0] s1, input bit s1u,
                         input logic [4:0] s2, input bit s2u,
                         input bit fire, input bit respect,
                         input bit iwe, input logic [4:0] idst,
                         input bit rwe, input logic [4:0] rdst);
        exp_t        e;
        bit          stall;
        bit          f;
        bit          inc;
        bit          dec;
        logic [31:0] busy;
        @(posedge clk);
        #1;
        busy = 32'h0;
        for (int i = 1; i < 32; i++) busy[i] = (pend[i] > 0);
        stall = v && ((s1u && busy[s1]) || (s2u && busy[s2]) ||
                      (iwe && idst != 5'd0 && pend[idst] == 3));
        f = fire && !(respect && stall);
        resetn      = rn;
        id_valid    = v;
        src1_addr   = s1;
        src1_used   = s1u;
        src2_addr   = s2;
        src2_used   = s2u;
        issue_fire  = f;
        issue_we    = iwe;
        issue_dest  = idst;
        retire_we   = rwe;
        retire_dest = rdst;
        e.stall = stall;
        e.busy  = busy;
        e.scnt  = m_scnt[15:0];
        e.err   = m_err;
        exp_q.push_back(e);
        if (!rn) begin
            model_clear();
        end else begin
            if (stall && m_scnt < 65535) m_scnt++;
            inc = f && iwe && idst != 5'd0;
            dec = rwe && rdst != 5'd0;
            if (!(inc && dec && idst == rdst)) begin
                if (inc && pend[idst] < 3) pend[idst]++;
                if (dec) begin
                    if (pend[rdst] > 0) pend[rdst]--;
                    else m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        cycle(1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
        idle();
    endtask

    // Monitor: every cycle the DUT presents a response, compare with the
    // oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_id_stall", {31'h0, id_stall}, {31'h0, e.stall});
            chk("sb_busy_vec", busy_vec, e.busy);
            chk("sb_stall_cnt", {16'h0, stall_cnt}, {16'h0, e.scnt});
            chk("sb_err_underflow", {31'h0, err_underflow}, {31'h0, e.err});
        end
    end

    initial begin
        resetn      = 1'b0;
        id_valid    = 1'b0;
        src1_addr   = 5'd0;
        src1_used   = 1'b0;
        src2_addr   = 5'd0;
        src2_used   = 1'b0;
        issue_fire  = 1'b0;
        issue_we    = 1'b0;
        issue_dest  = 5'd0;
        retire_we   = 1'b0;
        retire_dest = 5'd0;
        model_clear();
        do_reset();
        @(negedge clk);
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_stall_cnt", {16'h0, stall_cnt}, 32'd0);
        chk("reset_err", {31'h0, err_underflow}, 32'd0);

        // Read-after-write on r5, released one cycle after its retire.
        cycle(1, 1, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd5, 0, 5'd0);
        cycle(1, 1, 5'd5, 1, 5'd0, 0, 1, 1, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("raw_stall", {31'h0, id_stall}, 32'd1);
        chk("raw_busy", busy_vec, 32'h20);
        cycle(1, 1, 5'd5, 1, 5'd0, 0, 1, 1, 0, 5'd0, 0, 5'd0);
        cycle(1, 1, 5'd5, 1, 5'd0, 0, 1, 1, 0, 5'd0, 1, 5'd5);
        @(negedge clk);
        chk("retire_not_visible_stall", {31'h0, id_stall}, 32'd1);
        cycle(1, 1, 5'd5, 1, 5'd0, 0, 0, 1, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("raw_release_busy", busy_vec, 32'h0);
        chk("raw_release_stall", {31'h0, id_stall}, 32'd0);
        chk("raw_stall_cnt", {16'h0, stall_cnt}, 32'd3);

        // Saturation guard on r7.
        do_reset();
        for (int k = 0; k < 3; k++)
            cycle(1, 1, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd7, 0, 5'd0);
        cycle(1, 1, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd7, 0, 5'd0);
        @(negedge clk);
        chk("sat_stall", {31'h0, id_stall}, 32'd1);
        cycle(1, 1, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd7, 1, 5'd7);
        cycle(1, 1, 5'd0, 0, 5'd0, 0, 0, 1, 1, 5'd7, 0, 5'd0);
        @(negedge clk);
        chk("sat_release", {31'h0, id_stall}, 32'd0);

        // Same-cycle issue and retire of r9 with count 1.
        do_reset();
        cycle(1, 1, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd9, 0, 5'd0);
        cycle(1, 1, 5'd0, 0, 5'd0, 0, 1, 1, 1, 5'd9, 1, 5'd9);
        idle();
        @(negedge clk);
        chk("same_cycle_busy", busy_vec, 32'h200);
        cycle(1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 5'd9);
        idle();
        @(negedge clk);
        chk("same_cycle_count1", busy_vec, 32'h0);
        chk("same_cycle_no_err", {31'h0, err_underflow}, 32'd0);

        // Register 0 is never tracked.
        cycle(1, 1, 5'd0, 1, 5'd0, 1, 1, 1, 1, 5'd0, 0, 5'd0);
        cycle(1, 1, 5'd0, 1, 5'd0, 1, 0, 1, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("r0_busy", busy_vec, 32'h0);
        chk("r0_stall", {31'h0, id_stall}, 32'd0);

        // Underflow on r12 is sticky until reset.
        cycle(1, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 5'd12);
        idle();
        @(negedge clk);
        chk("underflow_set", {31'h0, err_underflow}, 32'd1);
        chk("underflow_busy", busy_vec, 32'h0);
        for (int k = 0; k < 4; k++) idle();
        @(negedge clk);
        chk("underflow_sticky", {31'h0, err_underflow}, 32'd1);

        // Reset with live counters, error and stall_cnt of 100.
        cycle(1, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 5'd3, 0, 5'd0);
        for (int k = 0; k < 100; k++)
            cycle(1, 1, 5'd3, 1, 5'd0, 0, 0, 1, 0, 5'd0, 0, 5'd0);
        idle();
        @(negedge clk);
        chk("pre_reset_stall_cnt", {16'h0, stall_cnt}, 32'd100);
        cycle(0, 1, 5'd0, 0, 5'd0, 0, 1, 0, 1, 5'd4, 1, 5'd3);
        idle();
        @(negedge clk);
        chk("post_reset_busy", busy_vec, 32'h0);
        chk("post_reset_stall_cnt", {16'h0, stall_cnt}, 32'd0);
        chk("post_reset_err", {31'h0, err_underflow}, 32'd0);

        // Randomized traffic over a small register window to force hazards.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(199) != 0),
                  $urandom_range(1),
                  5'($urandom_range(7)), $urandom_range(1),
                  5'($urandom_range(7)), $urandom_range(1),
                  $urandom_range(1), ($urandom_range(19) != 0),
                  $urandom_range(1), 5'($urandom_range(7)),
                  ($urandom_range(2) == 0), 5'($urandom_range(7)));
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have src1_addr  input  5  first source register of the decode-stage instruction (rj).
REQ-004 SHALL have src1_used  input  1  src1_addr is actually read by the decode-stage instruction.
REQ-005 SHALL have src2_addr  input  5  second source register (rk or rd).
REQ-006 SHALL have src2_used  input  1  src2_addr is actually read.
REQ-007 SHALL have id_valid  input  1  decode stage holds a valid instruction.
REQ-008 SHALL have issue_fire  input  1  decode-to-execute transfer occurs this cycle (valid & ready_go & execute allow_in).
REQ-009 SHALL have issue_we  input  1  issuing instruction writes the register file.
REQ-010 SHALL have issue_dest  input  5  destination register of the issuing instruction.
REQ-011 SHALL have retire_we  input  1  writeback stage commits a register write this cycle.
REQ-012 SHALL have retire_dest  input  5  register committed by writeback.
REQ-013 SHALL have id_stall  output  1  decode stage must hold (drives ready_go low).
REQ-014 SHALL have busy_vec  output  32  bit n set while register n has at least one write in flight.
REQ-015 SHALL have stall_cnt  output  16  number of cycles id_stall was asserted with id_valid high.
REQ-016 SHALL have err_underflow  output  1  sticky flag: retire seen for register with zero pending writes.

Function
REQ-017 SHALL keep one 2-bit pending counter per register 1..31; register 0 SHALL never be tracked and busy_vec[0] SHALL be constant 0.
REQ-018 SHALL increment counter[issue_dest] on rising clk when issue_fire & issue_we & issue_dest != 0.
REQ-019 SHALL decrement counter[retire_dest] on rising clk when retire_we & retire_dest != 0 & counter > 0.
REQ-020 SHALL leave a counter unchanged when increment and decrement target the same register in the same cycle.
REQ-021 SHALL apply independent increment and decrement to different registers in the same cycle.
REQ-022 SHALL set err_underflow when retire_we & retire_dest != 0 & counter[retire_dest] == 0 and no same-cycle increment of that register; counter stays 0.
REQ-023 SHALL drive busy_vec[n] = (counter[n] != 0), derived from registered state only (no same-cycle bypass).
REQ-024 SHALL assert id_stall combinationally when id_valid & ((src1_used & busy_vec[src1_addr]) | (src2_used & busy_vec[src2_addr])).
REQ-025 SHALL additionally assert id_stall when id_valid & issue_we & issue_dest != 0 & counter[issue_dest] == 3 (saturation guard).
REQ-026 SHALL NOT use issue_fire in computing id_stall (no combinational loop).
REQ-027 SHALL treat a retire in the current cycle as not yet visible: a source matching retire_dest with count 1 stalls this cycle and is released next cycle.
REQ-028 SHALL ignore an increment that would exceed 3 (counter saturates; cannot occur if REQ-025 is honoured).
REQ-029 SHALL increment stall_cnt by 1 each cycle id_stall & id_valid, saturating at 16'hFFFF.
REQ-030 SHALL be fully synchronous; no internal latency beyond one cycle from issue/retire edge to busy_vec update.

Reset
REQ-031 SHALL, while resetn is low at a rising clk, clear all counters, busy_vec to 32'h0, stall_cnt to 0, err_underflow to 0.
REQ-032 SHALL give reset priority over simultaneous issue/retire events in the same cycle.
REQ-033 SHALL drive id_stall low during and immediately after reset unless id_valid is high with a saturated destination (impossible post-reset).

Verification
REQ-034 SHALL pass: issue r5 write cycle 0; cycle 1 decode reads r5 (src1_used) -> id_stall=1, busy_vec=32'h20; retire r5 cycle 3 -> cycle 4 busy_vec=0, id_stall=0, stall_cnt=3.
REQ-035 SHALL pass: issue r7 three times back-to-back, no retire -> counter 3; fourth decode writing r7 -> id_stall=1; one retire r7 -> next cycle id_stall=0.
REQ-036 SHALL pass: same-cycle issue and retire of r9 with count 1 -> count remains 1, busy_vec[9]=1.
REQ-037 SHALL pass: issue r0 write, decode reads r0 -> busy_vec=0, id_stall=0.
REQ-038 SHALL pass: retire r12 with count 0 -> err_underflow=1 next cycle, stays 1 until resetn low.
REQ-039 SHALL pass: resetn low with counters nonzero and stall_cnt=100 -> next cycle busy_vec=0, stall_cnt=0, err_underflow=0.
